// File: rtl/serial_tx.sv
// 8-bit UART transmitter (8N1). Define SERIAL_TX_PARITY_EN to add an even-parity
// bit between the data bits and the stop bit.
module serial_tx #(
   parameter int CLK_HZ = 100000000,
   parameter int BAUD   = 115200
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       i_ready,
   output logic       uart_rxd_out,
   output logic       o_busy
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("serial_tx: CLK_HZ/BAUD must be at least 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef SERIAL_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             line_q, line_d;
   logic             rdy_en_q;
   logic             bit_done;
`ifdef SERIAL_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // rdy_en_q keeps i_ready low during reset and releases it on the first edge after.
   assign i_ready      = rdy_en_q && (state_q == IDLE);
   assign o_busy       = (state_q != IDLE);
   assign uart_rxd_out = line_q;
   assign bit_done     = (cnt_q == CNT_MAX);

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
`ifdef SERIAL_TX_PARITY_EN
      parity_d = parity_q;
`endif

      if (state_q != IDLE) begin
         cnt_d = bit_done ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (i_valid && i_ready) begin
               state_d  = START;
               shift_d  = i_data;
               cnt_d    = '0;
               idx_d    = '0;
`ifdef SERIAL_TX_PARITY_EN
               parity_d = ^i_data;
`endif
            end
         end
         START: begin
            if (bit_done) state_d = DATA;
         end
         DATA: begin
            if (bit_done) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (bit_done) state_d = STOP;
         end
`endif
         STOP: begin
            if (bit_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Line level is decoded from the next state so the output flop changes with the state.
      case (state_d)
         START:   line_d = 1'b0;
         DATA:    line_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
         PARITY:  line_d = parity_d;
`endif
         default: line_d = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         line_q   <= 1'b1;
         rdy_en_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         line_q   <= line_d;
         rdy_en_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: expected line levels come from a frame
// model built as a list of bit values, each held CLKS_PER_BIT cycles.
`timescale 1ns/1ps
module tb_serial_tx;

   localparam int CLK_HZ = 1000000;
   localparam int BAUD   = 100000;
   localparam int CPB    = CLK_HZ / BAUD;
`ifdef SERIAL_TX_PARITY_EN
   localparam int NBITS  = 11;
`else
   localparam int NBITS  = 10;
`endif
   localparam int FRAME_CYC = NBITS * CPB;

   logic       clk     = 1'b0;
   logic       nrst    = 1'b0;
   logic [7:0] i_data  = 8'h00;
   logic       i_valid = 1'b0;
   logic       i_ready;
   logic       uart_rxd_out;
   logic       o_busy;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   start_cyc;
   int   first_start;
   logic last_par;

   serial_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .i_ready      (i_ready),
      .uart_rxd_out (uart_rxd_out),
      .o_busy       (o_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // Waits (bounded) for i_ready, offers one byte and drops i_valid after the accepting edge.
   task automatic offer(input logic [7:0] b, input bit keep_valid);
      int n;
      n = 0;
      @(negedge clk);
      while (!i_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("offer_ready", i_ready, 1);
      i_data  = b;
      i_valid = 1'b1;
      @(posedge clk);
      #1;
      if (!keep_valid) i_valid = 1'b0;
   endtask

   // Called just after the accepting edge; checks every cycle of the frame plus the idle cycle.
   task automatic check_frame(input logic [7:0] b, input bit perturb);
      bit q[$];
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(b[i]);
`ifdef SERIAL_TX_PARITY_EN
      q.push_back(^b);
`endif
      q.push_back(1'b1);
      for (int k = 0; k < FRAME_CYC; k++) begin
         @(negedge clk);
         if (k == 0) start_cyc = cyc;
         check("line", uart_rxd_out, q[k / CPB]);
         check("busy", o_busy, 1);
         check("ready_in_frame", i_ready, 0);
         if (k == 9 * CPB + CPB / 2) last_par = uart_rxd_out;
         if (perturb) begin
            if (k == 2 * CPB) i_data = 8'h3C;
            i_valid = (k % 7 == 0) && (k < FRAME_CYC - 1);
         end
      end
      @(negedge clk);
      check("ready_after_frame", i_ready, 1);
      check("line_idle", uart_rxd_out, 1);
      check("busy_idle", o_busy, 0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_line", uart_rxd_out, 1);
      check("rst_ready", i_ready, 0);
      check("rst_busy", o_busy, 0);
      @(posedge clk);
      #1;
      check("rst_ready_edge", i_ready, 0);
      @(negedge clk);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      check("ready_first_edge", i_ready, 1);

      // Idle line with no traffic
      repeat (1000) begin
         @(negedge clk);
         check("idle_line", uart_rxd_out, 1);
         check("idle_busy", o_busy, 0);
      end

      // Directed frames, including parity polarity
      offer(8'hA5, 1'b0);
      check_frame(8'hA5, 1'b0);
`ifdef SERIAL_TX_PARITY_EN
      check("parity_a5", last_par, 0);
`endif
      offer(8'h07, 1'b0);
      check_frame(8'h07, 1'b0);
`ifdef SERIAL_TX_PARITY_EN
      check("parity_07", last_par, 1);
`endif

      // Back-to-back frames with i_valid held high
      offer(8'h00, 1'b1);
      i_data = 8'hFF;
      check_frame(8'h00, 1'b0);
      first_start = start_cyc;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      check_frame(8'hFF, 1'b0);
      check("b2b_period", start_cyc - first_start, FRAME_CYC + 1);

      // Data changes and valid pulses while busy are ignored
      offer(8'h5A, 1'b0);
      check_frame(8'h5A, 1'b1);
      i_valid = 1'b0;

      // Reset during data bit 3 (bit 3 of 0xC3 is 0, so the line is low before reset)
      offer(8'hC3, 1'b0);
      repeat (4 * CPB + 3) @(negedge clk);
      check("pre_abort_line", uart_rxd_out, 0);
      nrst = 1'b0;
      #1;
      check("abort_line", uart_rxd_out, 1);
      check("abort_ready", i_ready, 0);
      check("abort_busy", o_busy, 0);
      repeat (3) @(negedge clk);
      check("abort_hold_line", uart_rxd_out, 1);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_release_ready", i_ready, 1);
      offer(8'h11, 1'b0);
      check_frame(8'h11, 1'b0);

      // Random bytes against the model
      for (int r = 0; r < 4; r++) begin
         logic [7:0] b;
         b = 8'($urandom_range(0, 255));
         offer(b, 1'b0);
         check_frame(b, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate in bit/s.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_data  input  8  byte to transmit.
REQ-006 SHALL have port i_valid  input  1  i_data valid.
REQ-007 SHALL have port i_ready  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port uart_rxd_out  output  1  serial line toward host, idle high.
REQ-009 SHALL have port o_busy  output  1  frame in progress.

Function
REQ-010 SHALL derive CLKS_PER_BIT = CLK_HZ / BAUD (integer truncation); elaboration SHALL fail if CLKS_PER_BIT < 2.
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-012 SHALL assert i_ready only in IDLE; a byte is accepted on a rising edge with i_valid && i_ready.
REQ-013 SHALL latch i_data into a shift register on acceptance; later i_data changes SHALL not affect the frame.
REQ-014 SHALL ignore i_valid when i_ready is low (no buffering, no drop flag).
REQ-015 SHALL move IDLE->START on acceptance, driving uart_rxd_out low from the next cycle.
REQ-016 SHALL hold every bit (start, data, parity, stop) for exactly CLKS_PER_BIT cycles via a bit-period counter reset at each bit boundary.
REQ-017 SHALL send 8 data bits LSB first in DATA, using a 3-bit index that ends the state after bit 7.
REQ-018 SHALL drive uart_rxd_out high for one bit period in STOP, then return to IDLE with i_ready high on the following cycle.
REQ-019 SHALL make back-to-back frames possible: a byte offered continuously is accepted in the first IDLE cycle, giving a period of 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity).
REQ-020 SHALL drive uart_rxd_out from a flop (glitch-free), high in IDLE.
REQ-021 SHALL assert o_busy in every state except IDLE.

Reset
REQ-022 SHALL, while nrst is low, force state IDLE, uart_rxd_out=1, i_ready=0, o_busy=0, and clear counters and the shift register.
REQ-023 SHALL abort any frame in progress when nrst falls; the line goes high immediately.
REQ-024 SHALL assert i_ready on the first rising clk edge after nrst rises.

Configuration
REQ-025 SHALL, with SERIAL_TX_PARITY_EN defined, insert state PARITY between DATA and STOP, sending the even-parity bit (XOR of the 8 data bits) for one bit period.
REQ-026 SHALL, without SERIAL_TX_PARITY_EN, omit PARITY entirely (8N1 frame, DATA->STOP).

Verification (CLK_HZ=1000000, BAUD=100000, CLKS_PER_BIT=10)
REQ-027 SHALL check: send 0xA5 -> line 0 x10 cycles, then 1,0,1,0,0,1,0,1 x10 each, then 1 x10; i_ready high again 101 cycles after acceptance.
REQ-028 SHALL check: i_valid held high with 0x00 then 0xFF -> two frames, second start bit begins exactly 101 cycles after the first; no idle bit between frames beyond one cycle.
REQ-029 SHALL check: i_data changed to 0x3C in DATA state of a 0x5A frame -> line still carries 0x5A; i_valid pulses during busy are ignored.
REQ-030 SHALL check: nrst low during data bit 3 -> uart_rxd_out=1 and i_ready=0 immediately; i_ready=1 one edge after release; next 0x11 frame is correct.
REQ-031 SHALL check, SERIAL_TX_PARITY_EN defined: 0xA5 -> parity bit 0; 0x07 -> parity bit 1; frame 11 bit periods.
REQ-032 SHALL check: after reset with i_valid low for 1000 cycles -> uart_rxd_out stays 1, o_busy stays 0.
